// File: rtl/reg_commit_scheduler_pkg.sv
// Shared widths, zero constants and scheduler state encodings for the
// register-file commit scheduler.
package reg_commit_scheduler_pkg;

    localparam int REG_WIDTH  = 5;
    localparam int ROB_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;
    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        SCH_RUN   = 2'd0,
        SCH_DRAIN = 2'd1,
        SCH_FLUSH = 2'd2
    } sch_state_e;

    function automatic logic [1:0] push_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/reg_commit_scheduler_if.sv
// Commit-side and register-file-side signal bundle of the commit scheduler.
// master = ROB / register file side, slave = scheduler.
interface reg_commit_scheduler_if
    import reg_commit_scheduler_pkg::*;
#(
    parameter int REG_W  = REG_WIDTH,
    parameter int ROB_W  = ROB_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);

    logic              c0_valid;
    logic [REG_W-1:0]  c0_reg;
    logic [ROB_W-1:0]  c0_tag;
    logic [DATA_W-1:0] c0_value;
    logic              c1_valid;
    logic [REG_W-1:0]  c1_reg;
    logic [ROB_W-1:0]  c1_tag;
    logic [DATA_W-1:0] c1_value;
    logic              commit_ready;
    logic              in_rollback;
    logic [REG_W-1:0]  wr_reg;
    logic [ROB_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_value;
    logic              out_rollback;
    logic              rollback_busy;

    modport master (
        output c0_valid, c0_reg, c0_tag, c0_value,
        output c1_valid, c1_reg, c1_tag, c1_value,
        output in_rollback,
        input  commit_ready, wr_reg, wr_tag, wr_value, out_rollback, rollback_busy
    );

    modport slave (
        input  c0_valid, c0_reg, c0_tag, c0_value,
        input  c1_valid, c1_reg, c1_tag, c1_value,
        input  in_rollback,
        output commit_ready, wr_reg, wr_tag, wr_value, out_rollback, rollback_busy
    );

endinterface

// File: rtl/reg_commit_scheduler_commit_fifo.sv
// In-order FIFO with two write ports and one read port; write port 0 is
// always the older entry, and a lone push1 is compacted into the tail slot.
module reg_commit_scheduler_commit_fifo
    import reg_commit_scheduler_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int REG_W  = REG_WIDTH,
    parameter int ROB_W  = ROB_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0,
    input  logic [REG_W-1:0]         d0_reg,
    input  logic [ROB_W-1:0]         d0_tag,
    input  logic [DATA_W-1:0]        d0_value,
    input  logic                     push1,
    input  logic [REG_W-1:0]         d1_reg,
    input  logic [ROB_W-1:0]         d1_tag,
    input  logic [DATA_W-1:0]        d1_value,
    input  logic                     pop,
    output logic [REG_W-1:0]         head_reg,
    output logic [ROB_W-1:0]         head_tag,
    output logic [DATA_W-1:0]        head_value,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REG_W-1:0]  reg_mem   [DEPTH];
    logic [ROB_W-1:0]  tag_mem   [DEPTH];
    logic [DATA_W-1:0] value_mem [DEPTH];

    logic [AW-1:0]     head, tail, tail_b;
    logic [CW-1:0]     count_q;
    logic [1:0]        n_push;
    logic              wr_a, wr_b;
    logic [REG_W-1:0]  a_reg;
    logic [ROB_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_value;

    always_comb begin
        n_push  = push_count(push0, push1);
        wr_a    = push0 | push1;
        wr_b    = push0 & push1;
        a_reg   = push0 ? d0_reg   : d1_reg;
        a_tag   = push0 ? d0_tag   : d1_tag;
        a_value = push0 ? d0_value : d1_value;
        tail_b  = tail + AW'(1);
    end

    // Storage is data only: no reset, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            reg_mem[tail]   <= a_reg;
            tag_mem[tail]   <= a_tag;
            value_mem[tail] <= a_value;
        end
        if (wr_b) begin
            reg_mem[tail_b]   <= d1_reg;
            tag_mem[tail_b]   <= d1_tag;
            value_mem[tail_b] <= d1_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            tail    <= tail + AW'(n_push);
            if (pop == TRUE) begin
                head <= head + AW'(1);
            end
            count_q <= count_q + CW'(n_push) - CW'(pop);
        end
    end

    assign head_reg   = reg_mem[head];
    assign head_tag   = tag_mem[head];
    assign head_value = value_mem[head];
    assign count      = count_q;

endmodule

// File: rtl/reg_commit_scheduler.sv
// Buffers up to two retired register writes per cycle, drains one per cycle
// to the register file, and defers the rollback pulse until the buffer is empty.
module reg_commit_scheduler
    import reg_commit_scheduler_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int REG_W  = REG_WIDTH,
    parameter int ROB_W  = ROB_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    reg_commit_scheduler_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    sch_state_e        state, state_next;
    logic [CW-1:0]     count;
    logic              commit_ready, rollback_busy, out_rollback;
    logic              accept, push0, push1, vld_p0;
    logic [REG_W-1:0]  head_reg;
    logic [ROB_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_value;
    logic [REG_W-1:0]  wr_reg_p1;
    logic [ROB_W-1:0]  wr_tag_p1;
    logic [DATA_W-1:0] wr_value_p1;

    // Enqueue qualification; commit_ready already folds in state == RUN.
    always_comb begin
        accept = ena && commit_ready;
        push0  = accept && bus.c0_valid && (bus.c0_reg != REG_W'(ZERO_REG));
        push1  = accept && bus.c1_valid && (bus.c1_reg != REG_W'(ZERO_REG));
        vld_p0 = ena && (count != '0);
    end

    reg_commit_scheduler_commit_fifo #(
        .DEPTH  (DEPTH),
        .REG_W  (REG_W),
        .ROB_W  (ROB_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push0      (push0),
        .d0_reg     (bus.c0_reg),
        .d0_tag     (bus.c0_tag),
        .d0_value   (bus.c0_value),
        .push1      (push1),
        .d1_reg     (bus.c1_reg),
        .d1_tag     (bus.c1_tag),
        .d1_value   (bus.c1_value),
        .pop        (vld_p0),
        .head_reg   (head_reg),
        .head_tag   (head_tag),
        .head_value (head_value),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN leaves only once count is zero, so no pop shares that edge.
    always_comb begin
        state_next = state;
        if (ena) begin
            case (state)
                SCH_RUN:   if (bus.in_rollback) state_next = SCH_DRAIN;
                SCH_DRAIN: if (count == '0)     state_next = SCH_FLUSH;
                SCH_FLUSH: state_next = SCH_RUN;
                default:   state_next = SCH_RUN;
            endcase
        end
    end

    always_comb begin
        commit_ready  = FALSE;
        rollback_busy = TRUE;
        out_rollback  = FALSE;
        case (state)
            SCH_RUN: begin
                rollback_busy = FALSE;
                commit_ready  = (CW'(DEPTH) - count) >= CW'(2);
            end
            SCH_DRAIN: ;
            SCH_FLUSH: out_rollback = TRUE;
            default:   rollback_busy = FALSE;
        endcase
    end

    // Stage p1: registered write port; tag/value hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_reg_p1   <= REG_W'(ZERO_REG);
            wr_tag_p1   <= ROB_W'(ZERO_ROB);
            wr_value_p1 <= DATA_W'(ZERO_DATA);
        end else if (vld_p0) begin
            wr_reg_p1   <= head_reg;
            wr_tag_p1   <= head_tag;
            wr_value_p1 <= head_value;
        end else begin
            wr_reg_p1   <= REG_W'(ZERO_REG);
        end
    end

    assign bus.commit_ready  = commit_ready;
    assign bus.rollback_busy = rollback_busy;
    assign bus.out_rollback  = out_rollback;
    assign bus.wr_reg        = wr_reg_p1;
    assign bus.wr_tag        = wr_tag_p1;
    assign bus.wr_value      = wr_value_p1;

endmodule

// File: tb/tb_reg_commit_scheduler.sv
// Directed self-checking bench for reg_commit_scheduler (DEPTH=4).
module tb_reg_commit_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;

    int n_assert     = 0;
    int n_fail       = 0;
    int n_violations = 0;

    typedef struct packed {
        logic [4:0]  r;
        logic [3:0]  t;
        logic [31:0] v;
    } ent_t;

    reg_commit_scheduler_if #(.REG_W(5), .ROB_W(4), .DATA_W(32)) bus ();

    reg_commit_scheduler #(
        .DEPTH  (4),
        .REG_W  (5),
        .ROB_W  (4),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Commits offered while the scheduler is not ready are protocol violations.
    always @(negedge clk) begin
        if (rst && ena && !bus.commit_ready && (bus.c0_valid || bus.c1_valid))
            n_violations++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c0(input logic v, input logic [4:0] r, input logic [3:0] t, input logic [31:0] val);
        bus.c0_valid = v; bus.c0_reg = r; bus.c0_tag = t; bus.c0_value = val;
    endtask

    task automatic set_c1(input logic v, input logic [4:0] r, input logic [3:0] t, input logic [31:0] val);
        bus.c1_valid = v; bus.c1_reg = r; bus.c1_tag = t; bus.c1_value = val;
    endtask

    task automatic clear_commits();
        set_c0(1'b0, 5'd0, 4'd0, 32'd0);
        set_c1(1'b0, 5'd0, 4'd0, 32'd0);
    endtask

    initial begin
        ent_t q[$];
        ent_t e;
        int   sent;
        int   n_written;
        int   first_drop;

        clear_commits();
        bus.in_rollback = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b0;
        #1;
        check("rst_wr_reg",        bus.wr_reg,        0);
        check("rst_wr_tag",        bus.wr_tag,        0);
        check("rst_wr_value",      bus.wr_value,      0);
        check("rst_out_rollback",  bus.out_rollback,  0);
        check("rst_rollback_busy", bus.rollback_busy, 0);
        check("rst_commit_ready",  bus.commit_ready,  1);
        step();
        step();
        rst = 1'b1;
        ena = 1'b1;

        // Single commit
        set_c0(1'b1, 5'd5, 4'd3, 32'hDEADBEEF);
        step();
        clear_commits();
        check("single_lat0_wr_reg", bus.wr_reg, 0);
        step();
        check("single_wr_reg",   bus.wr_reg,   5);
        check("single_wr_tag",   bus.wr_tag,   3);
        check("single_wr_value", bus.wr_value, 32'hDEADBEEF);
        step();
        check("single_idle_wr_reg",   bus.wr_reg,   0);
        check("single_hold_wr_value", bus.wr_value, 32'hDEADBEEF);

        // Dual commit
        set_c0(1'b1, 5'd1, 4'd1, 32'h11);
        set_c1(1'b1, 5'd2, 4'd2, 32'h22);
        step();
        clear_commits();
        check("dual_ready", bus.commit_ready, 1);
        step();
        check("dual_first_reg",   bus.wr_reg,   1);
        check("dual_first_value", bus.wr_value, 32'h11);
        step();
        check("dual_second_reg",   bus.wr_reg,   2);
        check("dual_second_value", bus.wr_value, 32'h22);
        step();
        check("dual_idle", bus.wr_reg, 0);

        // Zero-register filter
        set_c0(1'b1, 5'd0, 4'd4, 32'h55);
        set_c1(1'b1, 5'd7, 4'd5, 32'h77);
        step();
        clear_commits();
        step();
        check("zero_filter_reg",   bus.wr_reg,   7);
        check("zero_filter_tag",   bus.wr_tag,   5);
        check("zero_filter_value", bus.wr_value, 32'h77);
        step();
        check("zero_filter_idle", bus.wr_reg, 0);

        // Back-pressure: dual commits whenever ready, 20 entries, scoreboard order
        sent = 0;
        n_written = 0;
        first_drop = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.commit_ready && sent < 20) begin
                set_c0(1'b1, 5'(sent + 1), 4'(sent), 32'hA0000000 + 32'(sent));
                set_c1(1'b1, 5'(sent + 2), 4'(sent + 1), 32'hA0000000 + 32'(sent + 1));
                q.push_back('{r: 5'(sent + 1), t: 4'(sent), v: 32'hA0000000 + 32'(sent)});
                q.push_back('{r: 5'(sent + 2), t: 4'(sent + 1), v: 32'hA0000000 + 32'(sent + 1)});
                sent += 2;
            end else begin
                clear_commits();
            end
            if (!bus.commit_ready && first_drop < 0)
                first_drop = cyc;
            step();
            if (bus.wr_reg != 0) begin
                if (q.size() == 0) begin
                    check("bp_unexpected_write", bus.wr_reg, 0);
                end else begin
                    e = q.pop_front();
                    check("bp_reg",   bus.wr_reg,   e.r);
                    check("bp_tag",   bus.wr_tag,   e.t);
                    check("bp_value", bus.wr_value, e.v);
                    n_written++;
                end
            end
            if (sent >= 20 && q.size() == 0)
                break;
        end
        clear_commits();
        check("bp_ready_drop_by_3", (first_drop >= 0 && first_drop <= 3), 1);
        check("bp_writes",          n_written, 20);
        check("bp_queue_empty",     q.size(),  0);
        step();

        // Rollback with 3 entries buffered
        set_c0(1'b1, 5'd10, 4'd1, 32'h100);
        set_c1(1'b1, 5'd11, 4'd2, 32'h101);
        step();
        check("rb_busy_pre", bus.rollback_busy, 0);
        set_c0(1'b1, 5'd12, 4'd3, 32'h102);
        set_c1(1'b1, 5'd13, 4'd4, 32'h103);
        step();
        check("rb_pre_wr", bus.wr_reg, 10);
        clear_commits();
        bus.in_rollback = 1'b1;
        step();
        check("rb_busy",      bus.rollback_busy, 1);
        check("rb_not_ready", bus.commit_ready,  0);
        check("rb_wr1",       bus.wr_reg,        11);
        check("rb_out1",      bus.out_rollback,  0);
        // Second pulse absorbed; commits while not ready must be ignored
        set_c0(1'b1, 5'd20, 4'd5, 32'h200);
        step();
        bus.in_rollback = 1'b0;
        clear_commits();
        check("rb_wr2",  bus.wr_reg,       12);
        check("rb_out2", bus.out_rollback, 0);
        step();
        check("rb_wr3",   bus.wr_reg,        13);
        check("rb_out3",  bus.out_rollback,  0);
        check("rb_busy3", bus.rollback_busy, 1);
        step();
        check("rb_flush_wr",    bus.wr_reg,        0);
        check("rb_flush_pulse", bus.out_rollback,  1);
        check("rb_flush_busy",  bus.rollback_busy, 1);
        check("rb_flush_ready", bus.commit_ready,  0);
        step();
        check("rb_done_pulse", bus.out_rollback,  0);
        check("rb_done_busy",  bus.rollback_busy, 0);
        check("rb_done_ready", bus.commit_ready,  1);
        step();
        check("rb_no_second_pulse", bus.out_rollback, 0);
        check("rb_ignored_commit",  bus.wr_reg,       0);

        // Rollback with an empty buffer
        bus.in_rollback = 1'b1;
        step();
        bus.in_rollback = 1'b0;
        check("rbe_busy",  bus.rollback_busy, 1);
        check("rbe_out0",  bus.out_rollback,  0);
        step();
        check("rbe_pulse", bus.out_rollback,  1);
        check("rbe_wr",    bus.wr_reg,        0);
        step();
        check("rbe_out2",  bus.out_rollback,  0);
        check("rbe_busy2", bus.rollback_busy, 0);
        check("rbe_ready", bus.commit_ready,  1);

        // Reset asserted mid-DRAIN
        set_c0(1'b1, 5'd14, 4'd6, 32'h140);
        set_c1(1'b1, 5'd15, 4'd7, 32'h150);
        step();
        set_c0(1'b1, 5'd16, 4'd8, 32'h160);
        set_c1(1'b1, 5'd17, 4'd9, 32'h170);
        step();
        clear_commits();
        bus.in_rollback = 1'b1;
        step();
        bus.in_rollback = 1'b0;
        check("mrst_pre_busy", bus.rollback_busy, 1);
        check("mrst_pre_wr",   bus.wr_reg,        15);
        #2 rst = 1'b0;
        #1;
        check("mrst_wr_reg", bus.wr_reg,        0);
        check("mrst_busy",   bus.rollback_busy, 0);
        check("mrst_ready",  bus.commit_ready,  1);
        check("mrst_out",    bus.out_rollback,  0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_post_wr",    bus.wr_reg,       0);
            check("mrst_post_pulse", bus.out_rollback, 0);
            check("mrst_post_ready", bus.commit_ready, 1);
        end

        // ena=0 with a backed-up buffer freezes everything
        set_c0(1'b1, 5'd21, 4'd6, 32'h300);
        set_c1(1'b1, 5'd22, 4'd7, 32'h301);
        step();
        set_c0(1'b1, 5'd23, 4'd8, 32'h302);
        set_c1(1'b1, 5'd24, 4'd9, 32'h303);
        step();
        check("frz_pre_wr",    bus.wr_reg,       21);
        check("frz_pre_ready", bus.commit_ready, 0);
        ena = 1'b0;
        bus.in_rollback = 1'b1;
        set_c0(1'b1, 5'd25, 4'd10, 32'h304);
        set_c1(1'b0, 5'd0, 4'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("frz_wr_reg",   bus.wr_reg,        0);
            check("frz_wr_tag",   bus.wr_tag,        6);
            check("frz_wr_value", bus.wr_value,      32'h300);
            check("frz_ready",    bus.commit_ready,  0);
            check("frz_busy",     bus.rollback_busy, 0);
            check("frz_out",      bus.out_rollback,  0);
        end
        clear_commits();
        bus.in_rollback = 1'b0;
        ena = 1'b1;
        step();
        check("frz_resume1", bus.wr_reg, 22);
        step();
        check("frz_resume2", bus.wr_reg, 23);
        step();
        check("frz_resume3",       bus.wr_reg,   24);
        check("frz_resume3_value", bus.wr_value, 32'h303);
        step();
        check("frz_resume_idle", bus.wr_reg,        0);
        check("frz_resume_busy", bus.rollback_busy, 0);

        check("protocol_violations", n_violations, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
